// File: rtl/uart_tx_driver.sv
// uart_tx_driver: 8N1 UART transmitter with a small byte FIFO.
// Bytes go out LSB first, and each serial bit lasts CLK_DIV clocks.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even parity bit
// is sent between the data bits and the stop bit, giving 8E1 framing.
module uart_tx_driver #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W = (CLK_DIV >= 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH >= 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  // Reject illegal parameterisations at elaboration time.
  if (CLK_DIV < 2) begin : g_bad_div
    $fatal(1, "uart_tx_driver: CLK_DIV must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "uart_tx_driver: FIFO_DEPTH must be a power of 2 and at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic push, pop, fifo_nempty, bit_last;

  assign fifo_nempty = (count_q != '0);
  assign bit_last    = (cnt_q == CNT_LAST);
  assign wr_ready    = (count_q != DEPTH_C);
  // A pop never frees room for a write in the same cycle, because wr_ready reads count_q.
  assign push        = wr_valid && wr_ready;
  assign pop         = fifo_nempty && ((state_q == IDLE) || ((state_q == STOP) && bit_last));

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || fifo_nempty;
  assign fifo_count = count_q;

  // The next occupancy follows from this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage has no reset because the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Update the FIFO pointers and occupancy; the pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Frame FSM: it drives tx from a register and holds each bit for CLK_DIV clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (fifo_nempty) begin
            shift_q <= mem_q[rd_ptr_q];
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_last) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_last) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= ^shift_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_last) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_last) begin
            cnt_q <= '0;
            // When the FIFO still holds data, the next start bit follows with no idle gap.
            if (fifo_nempty) begin
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_driver.sv
// Testbench for uart_tx_driver, built with CLK_DIV=4 and FIFO_DEPTH=4.
// A line monitor decodes the frames on tx and checks them against a scoreboard of expected bytes.
module tb_uart_tx_driver;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = CLK_DIV * NB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, tx, busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad = 0;
  int frames = 0;
  logic [7:0] exp_q[$];

  uart_tx_driver #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Return the expected line level for bit i of a frame that carries byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Offer one byte at the current negedge; it is accepted on the next posedge.
  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Wait until the scoreboard is empty and the DUT is idle, within a cycle budget.
  task automatic wait_drain(input int budget, output bit ok);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (exp_q.size() == 0) && (busy === 1'b0);
  endtask

  // Line monitor: samples each bit at mid-period, then checks the whole frame against the scoreboard.
  initial begin : monitor
    bit in_frame;
    int off;
    logic [10:0] bits;
    logic [7:0] e;
    int nbad;
    in_frame = 0;
    off = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_frame = 0;
      end else begin
        if (in_frame) off++;
        else if (tx === 1'b0) begin
          in_frame = 1;
          off = 0;
        end
        if (in_frame) begin
          if (off % CLK_DIV == CLK_DIV / 2) bits[off / CLK_DIV] = tx;
          if (off == FL - 1) begin
            in_frame = 0;
            frames++;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL monitor_unexpected_frame: got frame bits=%b, no byte expected", bits);
            end else begin
              e = exp_q.pop_front();
              nbad = 0;
              for (int i = 0; i < NB; i++) if (bits[i] !== frame_bit(e, i)) nbad++;
              if (nbad != 0) begin
                bad++;
                $display("FAIL monitor_frame: got data=%h bits=%b, expected data=%h", bits[8:1], bits, e);
              end
            end
          end
        end
      end
    end
  end

  // Watchdog: a hung run still reports a failure.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got tx=%b busy=%b expected 1/0", tx, busy); end
  endtask

  task automatic test_single_byte(input logic [7:0] b);
    logic [7:0] t;
    t = b;
    exp_q.push_back(t);
    write_byte(t);
    total++; if (tx !== 1'b1 || fifo_count !== 3'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL single_accept: got tx=%b count=%0d busy=%b expected 1/1/1", tx, fifo_count, busy);
    end
    for (int j = 0; j < FL; j++) begin
      @(negedge clk);
      total++;
      if (tx !== frame_bit(t, j / CLK_DIV)) begin
        bad++; $display("FAIL single_trace: cycle %0d got tx=%b expected %b", j, tx, frame_bit(t, j / CLK_DIV));
      end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_last: got %b expected 1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || tx !== 1'b1 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL single_idle: got busy=%b tx=%b count=%0d expected 0/1/0", busy, tx, fifo_count);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic tr[2*FL];
    logic [7:0] a, b;
    a = 8'h00;
    b = 8'hFF;
    exp_q.push_back(a);
    exp_q.push_back(b);
    write_byte(a);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL b2b_count_a: got %0d expected 1", fifo_count); end
    @(negedge clk);
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_count_b: got %0d expected 0", fifo_count); end
    tr[0] = tx;
    write_byte(b);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL b2b_count_c: got %0d expected 1", fifo_count); end
    tr[1] = tx;
    for (int j = 2; j < 2 * FL; j++) begin
      @(negedge clk);
      tr[j] = tx;
      if (j == FL - 1) begin
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL b2b_count_d: got %0d expected 1", fifo_count); end
      end
      if (j == FL) begin
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_count_e: got %0d expected 0", fifo_count); end
      end
    end
    for (int j = 0; j < 2 * FL; j++) begin
      logic e;
      e = (j < FL) ? frame_bit(a, j / CLK_DIV) : frame_bit(b, (j - FL) / CLK_DIV);
      total++;
      if (tr[j] !== e) begin bad++; $display("FAIL b2b_trace: cycle %0d got tx=%b expected %b", j, tr[j], e); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_fifo();
    logic [7:0] d[5];
    int f0;
    bit ok;
    d[0] = 8'h12; d[1] = 8'h34; d[2] = 8'h56; d[3] = 8'h78; d[4] = 8'h9A;
    f0 = frames;
    exp_q.push_back(8'h81);
    write_byte(8'h81);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (wr_ready !== (i < DEPTH)) begin
        bad++; $display("FAIL full_wr_ready: write %0d got %b expected %b", i, wr_ready, (i < DEPTH));
      end
      if (i < DEPTH) exp_q.push_back(d[i]);
      write_byte(d[i]);
    end
    total++; if (fifo_count !== 3'd4 || wr_ready !== 1'b0) begin
      bad++; $display("FAIL full_count: got count=%0d ready=%b expected 4/0", fifo_count, wr_ready);
    end
    wait_drain(7 * FL, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_drain: got pending=%0d busy=%b expected 0/0", exp_q.size(), busy); end
    total++; if (frames - f0 !== 5) begin bad++; $display("FAIL full_frames: got %0d frames expected 5", frames - f0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int f0, lows;
    bit ok;
    exp_q.push_back(8'hF0);
    write_byte(8'hF0);
    write_byte(8'h0F);
    repeat (17) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rst_mid_bit3: got tx=%b expected 0", tx); end
    reset = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
    total++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_state: got count=%0d busy=%b expected 0/0", fifo_count, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    f0 = frames;
    lows = 0;
    for (int j = 0; j < 3 * FL; j++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    total++; if (lows != 0 || frames != f0) begin
      bad++; $display("FAIL rst_residual: got low cycles=%0d frames=%0d expected 0/0", lows, frames - f0);
    end
    exp_q.push_back(8'h96);
    write_byte(8'h96);
    wait_drain(3 * FL, ok);
    total++; if (!ok || frames - f0 !== 1) begin
      bad++; $display("FAIL rst_next_byte: got pending=%0d frames=%0d expected 0/1", exp_q.size(), frames - f0);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] v[2];
    logic ep[2];
    logic par;
    int n;
    v[0] = 8'h07; ep[0] = 1'b1;
    v[1] = 8'h03; ep[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(v[k]);
      write_byte(v[k]);
      n = 0;
      par = 1'bx;
      @(negedge clk);
      while (busy === 1'b1 && n < 200) begin
        if (n == 38) par = tx;
        n++;
        @(negedge clk);
      end
      total++; if (par !== ep[k]) begin bad++; $display("FAIL parity_bit: byte %h got %b expected %b", v[k], par, ep[k]); end
      total++; if (n != 44) begin bad++; $display("FAIL parity_len: byte %h got %0d cycles expected 44", v[k], n); end
      repeat (2) @(negedge clk);
    end
  endtask
`endif

  task automatic test_push_pop();
    bit ok;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h3C);
    write_byte(8'h11);
    @(negedge clk);
    write_byte(8'h22);
    repeat (FL - 2) @(negedge clk);
    total++; if (fifo_count !== 3'd1 || tx !== 1'b1) begin
      bad++; $display("FAIL pp_before: got count=%0d tx=%b expected 1/1", fifo_count, tx);
    end
    write_byte(8'h3C);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL pp_count: got %0d expected 1", fifo_count); end
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL pp_next_start: got tx=%b expected 0", tx); end
    wait_drain(4 * FL, ok);
    total++; if (!ok) begin bad++; $display("FAIL pp_drain: got pending=%0d busy=%b expected 0/0", exp_q.size(), busy); end
  endtask

  initial begin
    test_reset();
    test_single_byte(8'hA5);
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_push_pop();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
